// File: rtl/inst_sram_axi_responder_pkg.sv
// Shared definitions for the instruction SRAM-to-AXI responder:
// FSM state encoding, fixed AXI read attributes and the kseg address mapping.
package inst_sram_axi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // kseg0/kseg1 both fold onto the low 512 MB; fetches are always word aligned.
    function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
        return {3'b000, vaddr[28:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_sram_axi_responder_last_buf.sv
// inst_last_buf: one-entry buffer holding the most recent good instruction fetch.
// Only present when INST_LAST_BUF_EN is defined.
`ifdef INST_LAST_BUF_EN
module inst_last_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fill_en,
    input  logic [29:0] fill_tag,
    input  logic [31:0] fill_data,
    input  logic [29:0] lookup_tag,
    output logic        hit,
    output logic [31:0] hit_data
);
    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;

    // Replace the entry whenever a good fetch completes; flush never clears it.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
    end

    // Entry storage; only reset invalidates it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit      = valid_q & (tag_q == lookup_tag);
    assign hit_data = data_q;

endmodule
`endif

// File: rtl/inst_sram_axi_responder.sv
// inst_sram_axi_responder: turns each accepted instruction fetch into one
// single-beat AXI read and returns the word with a one-cycle data_ok pulse.
// Build option: define INST_LAST_BUF_EN to add a one-entry last-fetch buffer
// that serves repeated fetches of the same word without AXI traffic.
//
// state | meaning
// IDLE  | no fetch outstanding, accepting requests
// AR    | arvalid high, address held until arready
// R     | rready high, waiting for the beat with our RID and rlast
// DONE  | response cycle; data_ok unless discarded or flushed now
module inst_sram_axi_responder
    import inst_sram_axi_responder_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_req_en,
    input  logic [31:0]     inst_req_addr,
    input  logic            inst_flush,
    output logic [31:0]     inst_rdata,
    output logic            inst_data_ok,
    output logic            inst_err,
    output logic            inst_stall,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);
    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        discard_q, discard_d;
    logic        accept;
    logic        beat_match;
    logic        unused_addr_bits;

    assign accept     = inst_req_en & ~inst_flush;
    assign beat_match = rvalid & (rid == AXI_ID) & rlast;

    // Segment bits and byte offset play no part in the physical word address.
    assign unused_addr_bits = ^{inst_req_addr[31:29], inst_req_addr[1:0]};

`ifdef INST_LAST_BUF_EN
    logic [29:0] vtag_q, vtag_d;
    logic        buf_fill;
    logic        buf_hit;
    logic [31:0] buf_data;

    // Discarded-but-good reads still refresh the buffer; the data is valid memory.
    assign buf_fill = (state_q == ST_DONE) & ~err_q;

    inst_last_buf u_last_buf (
        .clk        (clk),
        .resetn     (resetn),
        .fill_en    (buf_fill),
        .fill_tag   (vtag_q),
        .fill_data  (rdata_q),
        .lookup_tag (inst_req_addr[31:2]),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );

    // Remember the virtual word address of the accepted fetch for the buffer fill.
    always_comb begin
        vtag_d = vtag_q;
        if ((state_q == ST_IDLE) && accept) begin
            vtag_d = inst_req_addr[31:2];
        end
    end

    // Virtual tag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vtag_q <= '0;
        end else begin
            vtag_q <= vtag_d;
        end
    end
`endif

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        discard_d = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef INST_LAST_BUF_EN
                    if (buf_hit) begin
                        rdata_d = buf_data;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        araddr_d = kseg_map(inst_req_addr);
                        state_d  = ST_AR;
                    end
`else
                    araddr_d = kseg_map(inst_req_addr);
                    state_d  = ST_AR;
`endif
                end
            end
            ST_AR: begin
                // arvalid cannot be withdrawn, so a flush only marks the result as unwanted.
                if (inst_flush) begin
                    discard_d = 1'b1;
                end
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (inst_flush) begin
                    discard_d = 1'b1;
                end
                if (beat_match) begin
                    rdata_d = rdata;
                    err_d   = (rresp != RESP_OKAY);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                discard_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            araddr_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = LEN_SINGLE;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);

    assign inst_rdata   = rdata_q;
    assign inst_data_ok = (state_q == ST_DONE) & ~discard_q & ~inst_flush;
    assign inst_err     = inst_data_ok & err_q;
    assign inst_stall   = ((state_q != ST_IDLE) & ~((state_q == ST_DONE) & ~discard_q))
                        | ((state_q == ST_IDLE) & accept);

endmodule
